// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared opcode/funct constants, ALU and immediate-format enums
package core_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASS_B
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_fmt_e;

  // Opcode bits never contribute to an immediate, so only [31:7] is taken.
  function automatic logic [31:0] gen_imm(input logic [31:7] ins, input imm_fmt_e fmt);
    case (fmt)
      IMM_S:   gen_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   gen_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_J:   gen_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      IMM_U:   gen_imm = {ins[31:12], 12'h000};
      default: gen_imm = {{20{ins[31]}}, ins[31:20]};
    endcase
  endfunction

endpackage

// File: rtl/memory.sv
// rtl/memory.sv - big-endian byte memory: combinational fetch and read ports, synchronous word write
module memory #(
  parameter int MEM_BYTES = 1024,
  localparam int AW = $clog2(MEM_BYTES)
) (
  input  logic          clock,
  input  logic [AW-3:0] fetch_word,
  output logic [31:0]   fetch_data,
  input  logic [AW-3:0] rd_word,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [AW-3:0] wr_word,
  input  logic [31:0]   wr_data
);

  logic [7:0] data_RAM [0:MEM_BYTES-1];

  assign fetch_data = {data_RAM[{fetch_word, 2'd0}], data_RAM[{fetch_word, 2'd1}],
                       data_RAM[{fetch_word, 2'd2}], data_RAM[{fetch_word, 2'd3}]};
  assign rd_data    = {data_RAM[{rd_word, 2'd0}], data_RAM[{rd_word, 2'd1}],
                       data_RAM[{rd_word, 2'd2}], data_RAM[{rd_word, 2'd3}]};

  // No reset: contents survive reset so a program can be loaded while it is held.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      data_RAM[{wr_word, 2'd0}] <= wr_data[31:24];
      data_RAM[{wr_word, 2'd1}] <= wr_data[23:16];
      data_RAM[{wr_word, 2'd2}] <= wr_data[15:8];
      data_RAM[{wr_word, 2'd3}] <= wr_data[7:0];
    end
  end

endmodule

// File: rtl/core.sv
// rtl/core.sv - single-cycle RV32I-subset core over a unified instruction/data memory
// Define CORE_TRACE_EN to print pc, instruction and register writeback per executed instruction.
module core
  import core_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input logic clock,
  input logic reset,
  input logic mem_en
);

  localparam int AW = $clog2(MEM_BYTES);

  logic [31:0] pc;
  logic [31:0] regs [0:31];

  logic [31:0] instr, load_data, rs1_val, rs2_val, imm, alu_b, alu_y;
  logic [31:0] wb_val, pc_plus4, pc_next;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  alu_op_e     alu_op;
  imm_fmt_e    imm_fmt;
  logic        use_imm, reg_we, mem_rd, mem_wr, is_beq, is_bne, is_jal, taken;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  memory #(.MEM_BYTES(MEM_BYTES)) MainMemory (
    .clock      (clock),
    .fetch_word (pc[AW-1:2]),
    .fetch_data (instr),
    .rd_word    (alu_y[AW-1:2]),
    .rd_data    (load_data),
    .wr_en      (mem_wr && mem_en && !reset),
    .wr_word    (alu_y[AW-1:2]),
    .wr_data    (rs2_val)
  );

  always_comb begin
    alu_op  = ALU_ADD;
    imm_fmt = IMM_I;
    use_imm = 1'b1;
    reg_we  = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_jal  = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        reg_we = 1'b1;
        case (funct3)
          F3_ADD:  alu_op = ALU_ADD;
          F3_SLT:  alu_op = ALU_SLT;
          F3_XOR:  alu_op = ALU_XOR;
          F3_OR:   alu_op = ALU_OR;
          F3_AND:  alu_op = ALU_AND;
          default: reg_we = 1'b0;
        endcase
      end
      OPC_OP: begin
        use_imm = 1'b0;
        reg_we  = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, F3_ADD}: alu_op = ALU_ADD;
          {F7_ALT,  F3_ADD}: alu_op = ALU_SUB;
          {F7_BASE, F3_SLL}: alu_op = ALU_SLL;
          {F7_BASE, F3_SLT}: alu_op = ALU_SLT;
          {F7_BASE, F3_XOR}: alu_op = ALU_XOR;
          {F7_BASE, F3_SRL}: alu_op = ALU_SRL;
          {F7_ALT,  F3_SRL}: alu_op = ALU_SRA;
          {F7_BASE, F3_OR}:  alu_op = ALU_OR;
          {F7_BASE, F3_AND}: alu_op = ALU_AND;
          default:           reg_we = 1'b0;
        endcase
      end
      OPC_LUI: begin
        reg_we  = 1'b1;
        imm_fmt = IMM_U;
        alu_op  = ALU_PASS_B;
      end
      OPC_LOAD: begin
        reg_we = (funct3 == F3_LW);
        mem_rd = (funct3 == F3_LW);
      end
      OPC_STORE: begin
        imm_fmt = IMM_S;
        mem_wr  = (funct3 == F3_SW);
      end
      OPC_BRANCH: begin
        imm_fmt = IMM_B;
        is_beq  = (funct3 == F3_BEQ);
        is_bne  = (funct3 == F3_BNE);
      end
      OPC_JAL: begin
        imm_fmt = IMM_J;
        reg_we  = 1'b1;
        is_jal  = 1'b1;
      end
      default: ;
    endcase
  end

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign imm     = gen_imm(instr[31:7], imm_fmt);
  assign alu_b   = use_imm ? imm : rs2_val;

  always_comb begin
    alu_y = 32'd0;
    case (alu_op)
      ALU_ADD:    alu_y = rs1_val + alu_b;
      ALU_SUB:    alu_y = rs1_val - alu_b;
      ALU_AND:    alu_y = rs1_val & alu_b;
      ALU_OR:     alu_y = rs1_val | alu_b;
      ALU_XOR:    alu_y = rs1_val ^ alu_b;
      ALU_SLT:    alu_y = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      ALU_SLL:    alu_y = rs1_val << alu_b[4:0];
      ALU_SRL:    alu_y = rs1_val >> alu_b[4:0];
      ALU_SRA:    alu_y = $signed(rs1_val) >>> alu_b[4:0];
      ALU_PASS_B: alu_y = alu_b;
      default:    alu_y = 32'd0;
    endcase
  end

  assign pc_plus4 = pc + 32'd4;
  assign taken    = (is_beq && (rs1_val == rs2_val)) || (is_bne && (rs1_val != rs2_val));
  assign pc_next  = (is_jal || taken) ? pc + imm : pc_plus4;

  // A disabled data memory turns LW into a write of zero rather than a NOP.
  assign wb_val = is_jal ? pc_plus4 :
                  mem_rd ? (mem_en ? load_data : 32'd0) : alu_y;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= 32'd0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      pc <= pc_next;
      if (reg_we && (rd != 5'd0)) regs[rd] <= wb_val;
    end
  end

`ifdef CORE_TRACE_EN
  always @(posedge clock) begin
    if (!reset) begin
      if (reg_we && (rd != 5'd0))
        $display("trace pc=%08h instr=%08h wb x%0d=%08h", pc, instr, rd, wb_val);
      else
        $display("trace pc=%08h instr=%08h wb -", pc, instr);
    end
  end
`endif

endmodule

// File: tb/tb_core.sv
// tb/tb_core.sv - randomized and directed checks of core against an instruction-level model
module tb_core;

  localparam int MEMB = 1024;

  logic clock = 1'b0;
  logic reset;
  logic mem_en;

  int n_cmp;
  int n_err;

  logic [31:0] model_pc;
  logic [31:0] model_regs [0:31];
  logic [7:0]  model_mem  [0:MEMB-1];

  core #(.MEM_BYTES(MEMB)) dut (
    .clock  (clock),
    .reset  (reset),
    .mem_en (mem_en)
  );

  always #5 clock = ~clock;

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] e_i(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] e_s(input logic [4:0] rs2, input logic [4:0] rs1, input logic [31:0] imm);
    return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] e_b(input logic [2:0] f3, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [31:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] e_j(input logic [4:0] rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] e_u(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'h37};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] mword(input logic [31:0] addr);
    logic [31:0] a;
    a = (addr % MEMB) & ~32'd3;
    return {model_mem[a], model_mem[a+1], model_mem[a+2], model_mem[a+3]};
  endfunction

  function automatic void model_reset();
    model_pc = 32'd0;
    for (int r = 0; r < 32; r++) model_regs[r] = 32'd0;
  endfunction

  function automatic void model_step(input logic en);
    logic [31:0] ins, x, y, ii, si, bi, ji, v, nxt, a;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        we;
    ins = mword(model_pc);
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    rd  = ins[11:7];
    x   = model_regs[ins[19:15]];
    y   = model_regs[ins[24:20]];
    ii  = 32'($signed(ins[31:20]));
    si  = 32'($signed({ins[31:25], ins[11:7]}));
    bi  = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    ji  = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    nxt = model_pc + 32'd4;
    we  = 1'b0;
    v   = 32'd0;
    case (opc)
      7'h13: begin
        we = 1'b1;
        case (f3)
          3'd0: v = x + ii;
          3'd2: v = ($signed(x) < $signed(ii)) ? 32'd1 : 32'd0;
          3'd4: v = x ^ ii;
          3'd6: v = x | ii;
          3'd7: v = x & ii;
          default: we = 1'b0;
        endcase
      end
      7'h33: begin
        we = 1'b1;
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: v = x + y;
            3'd1: v = x << y[4:0];
            3'd2: v = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd4: v = x ^ y;
            3'd5: v = x >> y[4:0];
            3'd6: v = x | y;
            3'd7: v = x & y;
            default: we = 1'b0;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) v = x - y;
        else if (f7 == 7'h20 && f3 == 3'd5) v = 32'($signed(x) >>> y[4:0]);
        else we = 1'b0;
      end
      7'h37: begin we = 1'b1; v = {ins[31:12], 12'h000}; end
      7'h03: if (f3 == 3'd2) begin we = 1'b1; v = en ? mword(x + ii) : 32'd0; end
      7'h23: if (f3 == 3'd2 && en) begin
        a = ((x + si) % MEMB) & ~32'd3;
        for (int k = 0; k < 4; k++) model_mem[a+k] = y[31-8*k -: 8];
      end
      7'h63: if ((f3 == 3'd0 && x == y) || (f3 == 3'd1 && x != y)) nxt = model_pc + bi;
      7'h6f: begin we = 1'b1; v = model_pc + 32'd4; nxt = model_pc + ji; end
      default: ;
    endcase
    if (we && rd != 5'd0) model_regs[rd] = v;
    model_pc = nxt;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %08h expected %08h", name, idx, act, exp);
    end
  endtask

  task automatic compare_all();
    int bad;
    chk("pc", 0, dut.pc, model_pc);
    for (int r = 0; r < 32; r++) chk("x", r, dut.regs[r], model_regs[r]);
    bad = -1;
    for (int i = 0; i < MEMB; i++)
      if (bad < 0 && dut.MainMemory.data_RAM[i] !== model_mem[i]) bad = i;
    n_cmp++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL mem[%0d]: got %02h expected %02h", bad, dut.MainMemory.data_RAM[bad], model_mem[bad]);
    end
  endtask

  task automatic load(input logic [31:0] prog [$], input bit fill_rand);
    logic [7:0] b;
    for (int i = 0; i < MEMB; i++) begin
      b = fill_rand ? 8'($urandom) : 8'h00;
      model_mem[i] = b;
      dut.MainMemory.data_RAM[i] <= b;
    end
    foreach (prog[k]) begin
      for (int j = 0; j < 4; j++) begin
        b = prog[k][31-8*j -: 8];
        model_mem[4*k+j] = b;
        dut.MainMemory.data_RAM[4*k+j] <= b;
      end
    end
    #1;
  endtask

  // Load under reset, check the reset state, then release; leaves the bench at a falling edge.
  task automatic start(input logic [31:0] prog [$], input bit fill_rand);
    reset = 1'b1;
    model_reset();
    load(prog, fill_rand);
    @(negedge clock);
    compare_all();
    reset = 1'b0;
  endtask

  task automatic step(input logic en);
    mem_en = en;
    @(posedge clock);
    if (!reset) model_step(en);
    @(negedge clock);
    compare_all();
  endtask

  function automatic logic [31:0] rand_ins();
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, off;
    logic [6:0]  f7;
    logic [2:0]  f3;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    imm = 32'($urandom_range(0, 4095)) - 32'd2048;
    off = 32'($urandom_range(0, 8)) * 32'd4 - 32'd12;
    case ($urandom_range(0, 11))
      0, 1, 11: begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd2; 2: f3 = 3'd4; 3: f3 = 3'd6; default: f3 = 3'd7;
        endcase
        return e_i(7'h13, f3, rd, rs1, imm);
      end
      2, 3: begin
        f7 = 7'h00;
        case ($urandom_range(0, 9))
          0: f3 = 3'd0;
          1: begin f7 = 7'h20; f3 = 3'd0; end
          2: f3 = 3'd1;
          3: f3 = 3'd2;
          4: f3 = 3'd4;
          5: f3 = 3'd5;
          6: begin f7 = 7'h20; f3 = 3'd5; end
          7: f3 = 3'd6;
          8: f3 = 3'd7;
          default: begin f7 = 7'($urandom); f3 = 3'($urandom); end
        endcase
        return e_r(f7, f3, rd, rs1, rs2);
      end
      4: return e_u(rd, 20'($urandom));
      5, 6: return e_i(7'h03, 3'd2, rd, rs1, imm);
      7: return e_s(rs2, rs1, imm);
      8: return e_b(3'($urandom_range(0, 1)), rs1, rs2, off);
      9: return e_j(rd, off);
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] prog [$];
    logic [31:0] save_regs [0:31];
    logic [31:0] save_pc;
    int pulse_at;
    n_cmp  = 0;
    n_err  = 0;
    mem_en = 1'b1;
    reset  = 1'b1;

    // Arithmetic program loaded during reset
    prog = '{32'h00000000, 32'h05028293, 32'h01428213, 32'h00428533, 32'h40428633};
    start(prog, 1'b0);
    for (int c = 0; c < 5; c++) step(1'b1);
    chk("lit x5", 0, dut.regs[5], 32'd80);
    chk("lit x4", 0, dut.regs[4], 32'd100);
    chk("lit x10", 0, dut.regs[10], 32'd180);
    chk("lit x12", 0, dut.regs[12], 32'hFFFFFFEC);
    chk("lit pc", 0, dut.pc, 32'd20);
    chk("model x12", 0, model_regs[12], 32'hFFFFFFEC);

    // Store then load, big-endian bytes
    prog = '{e_i(7'h13, 3'd0, 5'd1, 5'd0, 32'h40), e_i(7'h13, 3'd0, 5'd2, 5'd0, 32'hFFFFFFF9),
             e_s(5'd2, 5'd1, 32'd0), e_i(7'h03, 3'd2, 5'd3, 5'd1, 32'd0)};
    start(prog, 1'b0);
    for (int c = 0; c < 4; c++) step(1'b1);
    chk("lit mem64", 0, {24'd0, dut.MainMemory.data_RAM[64]}, 32'hFF);
    chk("lit mem65", 0, {24'd0, dut.MainMemory.data_RAM[65]}, 32'hFF);
    chk("lit mem66", 0, {24'd0, dut.MainMemory.data_RAM[66]}, 32'hFF);
    chk("lit mem67", 0, {24'd0, dut.MainMemory.data_RAM[67]}, 32'hF9);
    chk("lit x3", 0, dut.regs[3], 32'hFFFFFFF9);
    chk("model x3", 0, model_regs[3], 32'hFFFFFFF9);

    // Same program with a reset pulse before the store: registers clear at once, no write
    start(prog, 1'b0);
    step(1'b1);
    step(1'b1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("async pc", 0, dut.pc, 32'd0);
    chk("async x1", 0, dut.regs[1], 32'd0);
    @(negedge clock);
    compare_all();
    chk("abort mem67", 0, {24'd0, dut.MainMemory.data_RAM[67]}, 32'h00);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) step(1'b1);
    chk("rerun x3", 0, dut.regs[3], 32'hFFFFFFF9);
    chk("rerun mem67", 0, {24'd0, dut.MainMemory.data_RAM[67]}, 32'hF9);

    // x0 discards writes
    prog = '{e_i(7'h13, 3'd0, 5'd6, 5'd0, 32'd7), e_i(7'h13, 3'd0, 5'd0, 5'd0, 32'd5),
             e_r(7'h00, 3'd0, 5'd6, 5'd0, 5'd0)};
    start(prog, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b1);
    chk("lit x0", 0, dut.regs[0], 32'd0);
    chk("lit x6", 0, dut.regs[6], 32'd0);

    // Branch taken / not taken at pc=12
    for (int t = 0; t < 2; t++) begin
      prog = '{e_i(7'h13, 3'd0, 5'd1, 5'd0, 32'd3), e_i(7'h13, 3'd0, 5'd2, 5'd0, 32'(3 + t)),
               32'h00000000, e_b(3'd0, 5'd1, 5'd2, 32'd8)};
      start(prog, 1'b0);
      for (int c = 0; c < 4; c++) step(1'b1);
      chk("lit beq pc", t, dut.pc, (t == 0) ? 32'd20 : 32'd16);
    end

    // Data memory disabled: store suppressed, load yields zero
    prog = '{e_i(7'h13, 3'd0, 5'd1, 5'd0, 32'h40), e_i(7'h13, 3'd0, 5'd2, 5'd0, 32'hFFFFFFF9),
             e_i(7'h13, 3'd0, 5'd3, 5'd0, 32'd9), e_s(5'd2, 5'd1, 32'd0),
             e_i(7'h03, 3'd2, 5'd3, 5'd1, 32'd0)};
    start(prog, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b1);
    step(1'b0);
    step(1'b0);
    chk("lit noen x3", 0, dut.regs[3], 32'd0);
    chk("lit noen mem64", 0, {24'd0, dut.MainMemory.data_RAM[64]}, 32'h00);

    // Random programs over randomized memory, random mem_en, occasional reset pulse
    for (int p = 0; p < 8; p++) begin
      prog = {};
      for (int k = 0; k < 40; k++) prog.push_back(rand_ins());
      start(prog, 1'b1);
      pulse_at = (p % 2 == 1) ? $urandom_range(10, 40) : -1;
      for (int c = 0; c < 60; c++) begin
        if (c == pulse_at) begin
          reset = 1'b1;
          model_reset();
          @(negedge clock);
          compare_all();
          reset = 1'b0;
        end
        step(($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0);
      end
    end

    // Deterministic rerun after mid-program reset reaches the same state
    prog = {};
    for (int k = 0; k < 20; k++) prog.push_back(rand_ins());
    start(prog, 1'b0);
    for (int c = 0; c < 25; c++) step(1'b1);
    save_pc = model_pc;
    for (int r = 0; r < 32; r++) save_regs[r] = model_regs[r];
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    compare_all();
    reset = 1'b0;
    for (int c = 0; c < 25; c++) step(1'b1);
    if (save_pc == model_pc) begin
      chk("rerun pc", 0, dut.pc, save_pc);
      for (int r = 0; r < 32; r++) chk("rerun x", r, dut.regs[r], save_regs[r]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
